// File: rtl/wb_stream_burst_reader_pkg.sv
// Shared constants and state encoding for the Wishbone burst reader.
package wb_stream_burst_reader_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: head word is visible on dout whenever empty is low.
module fifo_fwft #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   wr_en,
    output logic                   full,
    output logic [DATA_WIDTH-1:0]  dout,
    input  logic                   rd_en,
    output logic                   empty,
    output logic [DEPTH_WIDTH:0]   cnt
);

    localparam logic [DEPTH_WIDTH:0] DEPTH = (DEPTH_WIDTH + 1)'(2 ** DEPTH_WIDTH);

    logic [DATA_WIDTH-1:0]  mem [2 ** DEPTH_WIDTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic                   do_wr;
    logic                   do_rd;

    assign full  = (cnt == DEPTH);
    assign empty = (cnt == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
            if (do_rd) rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (DEPTH_WIDTH + 1)'(1);
                2'b01:   cnt <= cnt - (DEPTH_WIDTH + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_stream_burst_reader.sv
// Wishbone burst-read DMA master: reads buf_size words from start_adr into a
// FWFT FIFO that drains as a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for enable; latches start address and length
// WAIT  | between bursts; starts a burst once the FIFO has room for it
// READ  | incrementing burst on the bus, one FIFO push per ack
// DONE  | transfer finished or bus error; held until enable drops
module wb_stream_burst_reader
    import wb_stream_burst_reader_pkg::*;
#(
    parameter int WB_DW         = 32,
    parameter int WB_AW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2 ** FIFO_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    output logic [WB_DW-1:0]     stream_m_data_o,
    output logic                 stream_m_valid_o,
    input  logic                 stream_m_ready_i,
    input  logic                 enable,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    output logic                 busy,
    output logic                 done_o,
    output logic                 err_o
);

    localparam logic [FIFO_AW:0] DEPTH   = (FIFO_AW + 1)'(2 ** FIFO_AW);
    localparam logic [FIFO_AW:0] MAX_BL  = (FIFO_AW + 1)'(MAX_BURST_LEN);
    localparam logic [WB_AW-1:0] ADR_INC = WB_AW'(WB_DW / 8);

    state_e             state;
    state_e             state_next;
    logic [WB_AW-1:0]   adr;
    logic [WB_AW-1:0]   rem;
    logic [FIFO_AW:0]   beats_left;
    logic [FIFO_AW:0]   req_len;
    logic [FIFO_AW:0]   bl;
    logic [FIFO_AW:0]   fifo_cnt;
    logic [FIFO_AW:0]   free;
    logic               fifo_full;
    logic               fifo_empty;
    logic               beat_ok;
    logic               bus_err;
    logic               last_beat;

    // rty is a wait state; err wins over ack in the same cycle
    assign beat_ok   = (state == ST_READ) && wbm_ack_i && !wbm_err_i && !wbm_rty_i;
    assign bus_err   = (state == ST_READ) && wbm_err_i;
    assign last_beat = (beats_left == (FIFO_AW + 1)'(1));
    assign free      = DEPTH - fifo_cnt;

    // Burst length clamped to [1, MAX_BURST_LEN] and to the words still owed.
    always_comb begin
        if (burst_size == '0)
            req_len = (FIFO_AW + 1)'(1);
        else if (burst_size >= WB_AW'(MAX_BL))
            req_len = MAX_BL;
        else
            req_len = burst_size[FIFO_AW:0];
        if (rem < WB_AW'(req_len))
            bl = rem[FIFO_AW:0];
        else
            bl = req_len;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (enable) state_next = (buf_size == '0) ? ST_DONE : ST_WAIT;
            ST_WAIT: begin
                if (rem == '0)        state_next = ST_DONE;
                else if (!enable)     state_next = ST_IDLE;
                else if (free >= bl)  state_next = ST_READ;
            end
            ST_READ: begin
                if (bus_err)                   state_next = ST_DONE;
                else if (beat_ok && last_beat) state_next = ST_WAIT;
            end
            ST_DONE: if (!enable) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wbm_cyc_o = (state == ST_READ);
        wbm_stb_o = (state == ST_READ);
        busy      = (state == ST_WAIT) || (state == ST_READ);
        wbm_cti_o = CTI_CLASSIC;
        if (state == ST_READ)
            wbm_cti_o = (beats_left > (FIFO_AW + 1)'(1)) ? CTI_INC : CTI_EOB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr        <= '0;
            rem        <= '0;
            beats_left <= '0;
            err_o      <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= (state != ST_DONE) && (state_next == ST_DONE);
            if (state == ST_IDLE && enable) begin
                adr   <= start_adr;
                rem   <= buf_size;
                err_o <= 1'b0;
            end
            if (state == ST_WAIT && state_next == ST_READ)
                beats_left <= bl;
            if (beat_ok) begin
                adr        <= adr + ADR_INC;
                rem        <= rem - WB_AW'(1);
                beats_left <= beats_left - (FIFO_AW + 1)'(1);
            end
            if (bus_err)
                err_o <= 1'b1;
        end
    end

    assign wbm_adr_o = adr;
    assign wbm_dat_o = '0;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b0;
    assign wbm_bte_o = BTE_LINEAR;

    fifo_fwft #(
        .DATA_WIDTH  (WB_DW),
        .DEPTH_WIDTH (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .din   (wbm_dat_i),
        .wr_en (beat_ok && !fifo_full),
        .full  (fifo_full),
        .dout  (stream_m_data_o),
        .rd_en (stream_m_ready_i),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

    assign stream_m_valid_o = !fifo_empty;

endmodule

// File: doc/wb_stream_burst_reader.md
Name: wb_stream_burst_reader

Overview:
- Wishbone burst-read DMA master: fetches `buf_size` words from memory starting at `start_adr`.
- Fetched data goes into an internal first-word-fall-through FIFO and leaves as a valid/ready stream.
- Opposite direction to the stream-to-memory writer path: memory-to-stream, for feeding DACs, display and packet sources.
- Configuration arrives on plain ports, driven by a separate cfg block.

Parameters:
- WB_DW, 32, Wishbone/stream data width in bits (multiple of 8).
- WB_AW, 32, Wishbone byte address width.
- FIFO_AW, 4, log2 of FIFO depth (depth D = 2**FIFO_AW).
- MAX_BURST_LEN, 2**FIFO_AW, maximum beats per burst (must be <= D).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- wbm_adr_o  out  WB_AW  byte address
- wbm_dat_o  out  WB_DW  write data, constant 0
- wbm_sel_o  out  WB_DW/8  byte select, all ones
- wbm_we_o  out  1  constant 0
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_cti_o  out  3  cycle type
- wbm_bte_o  out  2  burst type, constant 2'b00
- wbm_dat_i  in  WB_DW  read data
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  error
- wbm_rty_i  in  1  retry
- stream_m_data_o  out  WB_DW  stream data
- stream_m_valid_o  out  1  stream valid
- stream_m_ready_i  in  1  stream ready
- enable  in  1  run request (level)
- start_adr  in  WB_AW  buffer byte address (word aligned)
- buf_size  in  WB_AW  transfer length in words
- burst_size  in  WB_AW  requested burst length in words
- busy  out  1  transfer in progress
- done_o  out  1  one-cycle pulse at transfer end
- err_o  out  1  sticky bus-error flag

Behaviour:
- Interface (already decided): one clock `clk`; `rst` is synchronous, active-high.
- Reset: cyc/stb/busy/done_o/err_o = 0; cti = 0; adr = 0; FIFO flushed; stream_m_valid_o = 0; FSM = IDLE. Reset mid-burst drops cyc/stb the next cycle, with no completion.
- Burst length: BL = min(max(burst_size, 1), MAX_BURST_LEN, remaining).
- FSM IDLE:
  - enable = 1 latches adr <= start_adr and rem <= buf_size, clears err_o, sets busy, goes to WAIT.
  - If buf_size == 0, go to DONE directly.
- FSM WAIT:
  - If rem == 0, go to DONE.
  - Else if enable = 0, go to IDLE with busy = 0 and no done pulse.
  - Else if free space (D - fifo_cnt) >= BL, latch beat counter = BL and go to READ.
- FSM READ:
  - cyc = stb = 1.
  - cti = 3'b010 while beats_left > 1; cti = 3'b111 on the last beat (single-beat bursts use 3'b111).
  - On each ack: push wbm_dat_i into the FIFO, adr += WB_DW/8, rem -= 1, beats_left -= 1.
  - After the last ack, deassert cyc/stb the next cycle and go to WAIT. At least one idle cycle between bursts.
- Bus conditions in READ:
  - rty is treated as a wait state: no push, no advance.
  - err (priority over ack in the same cycle): no push; err_o <= 1; drop cyc/stb; go to DONE.
- enable falling in READ: the current burst completes; the check happens in WAIT.
- FSM DONE: done_o pulses exactly one cycle; busy = 0; stays in DONE until enable = 0, then goes to IDLE. This prevents auto-restart.
- Address arithmetic wraps modulo 2**WB_AW with no boundary check.
- FIFO never overflows, because a burst starts only when space >= BL. Push and pop in the same cycle are legal.
- Stream side:
  - stream_m_valid_o = !fifo_empty; data is the FIFO head (FWFT).
  - Pop on valid & ready.
  - Data and valid are held stable while ready = 0.
  - Draining continues after DONE; done_o does not wait for the stream to empty.
- Latency: first stream word valid 1 cycle after its ack.

Decomposition:
- Shared package constants: CTI_CLASSIC = 3'b000, CTI_INC = 3'b010, CTI_EOB = 3'b111, BTE_LINEAR = 2'b00; FSM state encoding (IDLE, WAIT, READ, DONE).
- One sub-module: the existing `fifo_fwft` (DATA_WIDTH = WB_DW, DEPTH_WIDTH = FIFO_AW, with `cnt` output), instantiated for buffering.
- The FSM and address/counter logic stay in the top.

Test Plan:
- start_adr = 0x1000, buf_size = 8, burst_size = 4, zero-wait slave, ready = 1 -> two bursts, adr 0x1000..0x100C then 0x1010..0x101C, cti 2,2,2,7 each, stream yields the 8 memory words in order, one done_o pulse.
- buf_size = 5, burst_size = 4 -> bursts of 4 then 1; second burst cti = 7 on its single beat; rem reaches 0.
- FIFO_AW = 2, burst_size = 4, ready = 0 -> one burst fills the FIFO, no new cyc until 4 words are popped; valid held with data stable throughout.
- err_i on beat 2 of a 4-beat burst -> 1 word pushed, err_o = 1, cyc drops next cycle, done_o pulses.
- Random ack delays with rty_i pulses -> no duplicated or lost words, addresses strictly incrementing by 4.
- rst asserted mid-burst -> cyc/stb/valid = 0 next cycle; re-enable with buf_size = 0 -> done_o pulse, no bus cycle.
